// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulation path: FSM state encoding and
// default lane/psum/latency widths used by mac_acc_ctrl and mac_wrapper users.
package mac_pkg;

  localparam int MAC_BW      = 4;
  localparam int MAC_PSUM_BW = 16;
  localparam int MAC_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a down-counter that must hold lat-1; never narrower than one bit.
  function automatic int wait_bw(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mac_acc_ctrl.sv
// Sequences 4-lane operand beats into an external mac_wrapper, feeding each
// partial sum back through mac_c until the last beat, then presents the result.
module mac_acc_ctrl
  import mac_pkg::*;
#(
  parameter int bw      = MAC_BW,
  parameter int psum_bw = MAC_PSUM_BW,
  parameter int mac_lat = MAC_LAT,
  parameter int cnt_bw  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*bw-1:0]     in_a,
  input  logic [4*bw-1:0]     in_b,
  input  logic                in_last,
  output logic [bw-1:0]       mac_a0,
  output logic [bw-1:0]       mac_a1,
  output logic [bw-1:0]       mac_a2,
  output logic [bw-1:0]       mac_a3,
  output logic [bw-1:0]       mac_b0,
  output logic [bw-1:0]       mac_b1,
  output logic [bw-1:0]       mac_b2,
  output logic [bw-1:0]       mac_b3,
  output logic [psum_bw-1:0]  mac_c,
  input  logic [psum_bw-1:0]  mac_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [psum_bw-1:0]  out_psum,
  output logic [cnt_bw-1:0]   out_cnt,
  output logic                out_ovf
);

  localparam int                 WAIT_BW   = wait_bw(mac_lat);
  localparam logic [WAIT_BW-1:0] WAIT_INIT = WAIT_BW'(mac_lat - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [WAIT_BW-1:0]   r_wait_cnt;
  logic [psum_bw-1:0]   r_acc;
  logic [cnt_bw-1:0]    r_cnt;
  logic                 r_ovf;
  logic                 r_last;
  logic                 r_first;

  logic                 w_accept;
  logic                 w_capture;
  logic                 w_release;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_capture = (r_state == ST_WAIT) && (r_wait_cnt == '0);
  assign w_release = (r_state == ST_DONE) && out_ready;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) w_next_state = r_last ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_a0     <= '0;
      mac_a1     <= '0;
      mac_a2     <= '0;
      mac_a3     <= '0;
      mac_b0     <= '0;
      mac_b1     <= '0;
      mac_b2     <= '0;
      mac_b3     <= '0;
      mac_c      <= '0;
      r_wait_cnt <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_last     <= 1'b0;
      r_first    <= 1'b1;
    end else begin
      if (w_accept) begin
        mac_a0     <= in_a[0*bw +: bw];
        mac_a1     <= in_a[1*bw +: bw];
        mac_a2     <= in_a[2*bw +: bw];
        mac_a3     <= in_a[3*bw +: bw];
        mac_b0     <= in_b[0*bw +: bw];
        mac_b1     <= in_b[1*bw +: bw];
        mac_b2     <= in_b[2*bw +: bw];
        mac_b3     <= in_b[3*bw +: bw];
        mac_c      <= r_first ? '0 : r_acc;
        r_last     <= in_last;
        r_wait_cnt <= WAIT_INIT;
        r_first    <= 1'b0;
        if (r_first) begin
          r_cnt <= cnt_bw'(1);
          r_ovf <= 1'b0;
        end else begin
          r_cnt <= r_cnt + cnt_bw'(1);
          // Sticky: once the count wraps, the vector is flagged until it ends.
          if (&r_cnt) r_ovf <= 1'b1;
        end
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_BW'(1);
      end

      if (w_capture) r_acc   <= mac_out;
      if (w_release) r_first <= 1'b1;
    end
  end

  assign out_psum = r_acc;
  assign out_cnt  = r_cnt;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Directed bench for mac_acc_ctrl with a behavioural mac_wrapper model
// (input register plus combinational dot product), mac_lat = 2, cnt_bw = 2.
module tb_mac_acc_ctrl;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [4*BW-1:0]     in_a;
  logic [4*BW-1:0]     in_b;
  logic                in_last;
  logic [BW-1:0]       mac_a0, mac_a1, mac_a2, mac_a3;
  logic [BW-1:0]       mac_b0, mac_b1, mac_b2, mac_b3;
  logic [PSUM_BW-1:0]  mac_c;
  logic [PSUM_BW-1:0]  mac_out;
  logic                out_valid;
  logic                out_ready;
  logic [PSUM_BW-1:0]  out_psum;
  logic [CNT_BW-1:0]   out_cnt;
  logic                out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_acc_ctrl #(
    .bw(BW), .psum_bw(PSUM_BW), .mac_lat(2), .cnt_bw(CNT_BW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
    .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2), .mac_b3(mac_b3),
    .mac_c(mac_c), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  // Behavioural mac_wrapper: one input register stage, combinational mac.
  logic [4*BW-1:0]    wr_a, wr_b;
  logic [PSUM_BW-1:0] wr_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_a <= '0;
      wr_b <= '0;
      wr_c <= '0;
    end else begin
      wr_a <= {mac_a3, mac_a2, mac_a1, mac_a0};
      wr_b <= {mac_b3, mac_b2, mac_b1, mac_b0};
      wr_c <= mac_c;
    end
  end

  function automatic logic [PSUM_BW-1:0] dot4(input logic [4*BW-1:0] a,
                                              input logic [4*BW-1:0] b,
                                              input logic [PSUM_BW-1:0] c);
    logic [PSUM_BW-1:0] s;
    s = c;
    for (int i = 0; i < 4; i++)
      s = s + PSUM_BW'(a[i*BW +: BW]) * PSUM_BW'(b[i*BW +: BW]);
    return s;
  endfunction

  assign mac_out = dot4(wr_a, wr_b, wr_c);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_mac_a"},     32'({mac_a3, mac_a2, mac_a1, mac_a0}), 32'h0);
    check({tag, "_mac_b"},     32'({mac_b3, mac_b2, mac_b1, mac_b0}), 32'h0);
    check({tag, "_mac_c"},     32'(mac_c), 32'd0);
    check({tag, "_out_psum"},  32'(out_psum), 32'd0);
    check({tag, "_out_cnt"},   32'(out_cnt), 32'd0);
    check({tag, "_out_ovf"},   32'(out_ovf), 32'd0);
  endtask

  // Present one beat, accept it on the next edge, then wait out the two WAIT edges.
  task automatic run_beat(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b,
                          input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // 1. Single beat: 1+2+3+4 = 10
    in_valid = 1'b1;
    in_a     = 16'h1234;
    in_b     = 16'h1111;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_in_ready_after_accept", 32'(in_ready), 32'd0);
    check("t1_mac_a", 32'({mac_a3, mac_a2, mac_a1, mac_a0}), 32'h1234);
    check("t1_mac_b", 32'({mac_b3, mac_b2, mac_b1, mac_b0}), 32'h1111);
    check("t1_mac_c", 32'(mac_c), 32'd0);
    tick();
    check("t1_out_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("t1_out_valid_e2", 32'(out_valid), 32'd1);
    check("t1_out_psum", 32'(out_psum), 32'd10);
    check("t1_out_cnt",  32'(out_cnt), 32'd1);
    check("t1_out_ovf",  32'(out_ovf), 32'd0);
    check("t1_in_ready_done", 32'(in_ready), 32'd0);
    release_result();
    check("t1_out_valid_released", 32'(out_valid), 32'd0);
    check("t1_in_ready_released", 32'(in_ready), 32'd1);

    // 2. Three beats of the same operands: 30, in_ready low exactly 2 cycles
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a     = 16'h1234;
      in_b     = 16'h1111;
      in_last  = (k == 2);
      tick();
      in_valid = 1'b0;
      check($sformatf("t2_b%0d_ready_c1", k), 32'(in_ready), 32'd0);
      check($sformatf("t2_b%0d_mac_c", k), 32'(mac_c), 32'(10 * k));
      tick();
      check($sformatf("t2_b%0d_ready_c2", k), 32'(in_ready), 32'd0);
      tick();
      if (k < 2) check($sformatf("t2_b%0d_ready_c3", k), 32'(in_ready), 32'd1);
    end
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_psum",  32'(out_psum), 32'd30);
    check("t2_out_cnt",   32'(out_cnt), 32'd3);
    check("t2_out_ovf",   32'(out_ovf), 32'd0);

    // 3. Backpressure: result held while a new beat waits at the input
    in_valid = 1'b1;
    in_a     = 16'h2222;
    in_b     = 16'h3333;
    in_last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("t3_c%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("t3_c%0d_out_psum", k), 32'(out_psum), 32'd30);
      check($sformatf("t3_c%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    release_result();
    check("t3_in_ready_after_release", 32'(in_ready), 32'd1);
    check("t3_mac_a_not_relaunched", 32'({mac_a3, mac_a2, mac_a1, mac_a0}), 32'h1234);

    // 4. Input gap between beats: 4*(2*3) = 24 per beat, 48 total
    tick();
    in_valid = 1'b0;
    check("t4_b0_mac_c", 32'(mac_c), 32'd0);
    check("t4_b0_mac_a", 32'({mac_a3, mac_a2, mac_a1, mac_a0}), 32'h2222);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_gap%0d_in_ready", k), 32'(in_ready), 32'd1);
      check($sformatf("t4_gap%0d_out_valid", k), 32'(out_valid), 32'd0);
      tick();
    end
    check("t4_acc_kept", 32'(out_psum), 32'd24);
    in_valid = 1'b1;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_b1_mac_c", 32'(mac_c), 32'd24);
    tick();
    tick();
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_out_psum",  32'(out_psum), 32'd48);
    check("t4_out_cnt",   32'(out_cnt), 32'd2);
    release_result();

    // 5. Reset one cycle after accepting beat 2, then a clean single beat (5*3 = 15)
    run_beat(16'h1111, 16'h1111, 1'b0);
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h1111;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_b1_mac_c", 32'(mac_c), 32'd4);
    tick();
    reset = 1'b1;
    #1;
    check_reset_values("t5_rst");
    tick();
    reset = 1'b0;
    tick();
    run_beat(16'h0005, 16'h0003, 1'b1);
    check("t5_out_valid", 32'(out_valid), 32'd1);
    check("t5_out_psum",  32'(out_psum), 32'd15);
    check("t5_out_cnt",   32'(out_cnt), 32'd1);
    check("t5_out_ovf",   32'(out_ovf), 32'd0);
    release_result();

    // 6. Five beats with a 2-bit counter: count wraps to 1, overflow sticky
    for (int k = 0; k < 5; k++) run_beat(16'h0001, 16'h0001, (k == 4));
    check("t6_out_valid", 32'(out_valid), 32'd1);
    check("t6_out_psum",  32'(out_psum), 32'd5);
    check("t6_out_cnt",   32'(out_cnt), 32'd1);
    check("t6_out_ovf",   32'(out_ovf), 32'd1);
    release_result();
    run_beat(16'h0007, 16'h0002, 1'b1);
    check("t6_next_psum", 32'(out_psum), 32'd14);
    check("t6_next_cnt",  32'(out_cnt), 32'd1);
    check("t6_next_ovf",  32'(out_ovf), 32'd0);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
